// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with an AXI-Stream style single-entry output register.
// Counts clk cycles from the start edge to sample each bit near its centre.
module uart_byte_rx #(
   parameter int CLKS_PER_BIT = 250,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  uart_rxd,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  overrun_error
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [15:0]   HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]   FULL_LOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

   logic [2:0]            state_r, state_nx_s;
   logic [15:0]           cnt_r, cnt_nx_s;
   logic [BW-1:0]         bit_r, bit_nx_s;
   logic [DATA_WIDTH-1:0] shreg_r, shreg_nx_s;
   logic                  prev_rxd_r;
   logic                  sample_s;
   logic                  start_det_s;
   logic                  stop_ok_s;
   logic                  stop_bad_s;

   assign sample_s    = (cnt_r == 16'd0);
   assign start_det_s = ~uart_rxd & prev_rxd_r;
   assign stop_ok_s   = (state_r == ST_STOP) & sample_s & uart_rxd;
   assign stop_bad_s  = (state_r == ST_STOP) & sample_s & ~uart_rxd;

   // Next-state, sample-point counter and shift register update
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      bit_nx_s   = bit_r;
      shreg_nx_s = shreg_r;
      case (state_r)
         ST_IDLE: begin
            if (start_det_s) begin
               state_nx_s = ST_START;
               cnt_nx_s   = HALF_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (!sample_s) begin
               cnt_nx_s = cnt_r - 16'd1;
            end else if (uart_rxd) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DATA;
               cnt_nx_s   = FULL_LOAD;
               bit_nx_s   = '0;
            end
         end
         ST_DATA: begin
            if (!sample_s) begin
               cnt_nx_s = cnt_r - 16'd1;
            end else begin
               shreg_nx_s = {uart_rxd, shreg_r[DATA_WIDTH-1:1]};
               cnt_nx_s   = FULL_LOAD;
               if (bit_r == LAST_BIT) begin
                  state_nx_s = ST_STOP;
               end else begin
                  bit_nx_s = bit_r + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (!sample_s) begin
               cnt_nx_s = cnt_r - 16'd1;
            end else begin
               state_nx_s = uart_rxd ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            // a held-low line must go high before any new start edge counts
            if (uart_rxd) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_BREAK;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 16'd0;
         end
      endcase
   end

   // State registers and registered stream/status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 16'd0;
         bit_r         <= '0;
         shreg_r       <= '0;
         prev_rxd_r    <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         busy          <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         cnt_r         <= cnt_nx_s;
         bit_r         <= bit_nx_s;
         shreg_r       <= shreg_nx_s;
         prev_rxd_r    <= uart_rxd;
         busy          <= (state_nx_s != ST_IDLE);
         frame_error   <= stop_bad_s;
         overrun_error <= stop_ok_s & m_axis_tvalid & ~m_axis_tready;
         // a completing byte wins over the handshake so nothing is dropped
         if (stop_ok_s) begin
            m_axis_tdata  <= shreg_r;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end else begin
            m_axis_tvalid <= m_axis_tvalid;
         end
      end
   end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: frame vectors, corner-case sequences and
// random frames compared against expectations derived from bit timing arithmetic.
module tb_uart_byte_rx;
   localparam int CPB = 250;
   localparam int H   = CPB / 2;
   localparam int LAT = H + 9 * CPB + 1;   // start edge cycle to output cycle

   logic       clk = 1'b0;
   logic       reset_n, uart_rxd, tready;
   logic [7:0] tdata;
   logic       tvalid, busy, fe, oe;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] beat_d[$];
   int         beat_t[$];
   int         fe_t[$];
   int         oe_t[$];
   int         tv_cycles, busy_first, busy_last;
   logic       busy_seen;

   uart_byte_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .uart_rxd(uart_rxd),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .busy(busy), .frame_error(fe), .overrun_error(oe)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // observe the outputs half a cycle away from the active edge
   always @(negedge clk) begin
      if (tvalid && tready) begin
         beat_d.push_back(tdata);
         beat_t.push_back(cyc);
      end
      if (tvalid) tv_cycles++;
      if (fe) fe_t.push_back(cyc);
      if (oe) oe_t.push_back(cyc);
      if (busy) begin
         if (!busy_seen) busy_first = cyc;
         busy_seen = 1'b1;
         busy_last = cyc;
      end
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      beat_d.delete(); beat_t.delete(); fe_t.delete(); oe_t.delete();
      tv_cycles = 0; busy_seen = 1'b0; busy_first = -1; busy_last = -1;
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drives one full frame; t0 is the cycle in which the start bit first appears
   task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      uart_rxd = 1'b1;
   endtask

   vec_t       vecs[5];
   logic [7:0] exp_d[$];
   int         exp_t[$];
   int         t0, t1;
   logic [7:0] rd;

   initial begin
      vecs[0] = '{8'h55, 1'b1};
      vecs[1] = '{8'h00, 1'b1};
      vecs[2] = '{8'hFF, 1'b1};
      vecs[3] = '{8'hA5, 1'b1};
      vecs[4] = '{8'h12, 1'b0};

      clear_mon();
      uart_rxd = 1'b0; tready = 1'b1; reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_tdata", {24'd0, tdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fe", {31'd0, fe}, 32'd0);
      check("rst_oe", {31'd0, oe}, 32'd0);
      reset_n = 1'b1;
      // line low straight out of reset is not a start edge
      repeat (20) @(posedge clk);
      #1;
      check("no_start_after_rst", {31'd0, busy_seen}, 32'd0);
      idle(20);

      // table of single frames with tready held high
      for (int v = 0; v < 5; v++) begin
         clear_mon();
         send_frame(vecs[v].data, vecs[v].stop, t0);
         idle(10);
         if (vecs[v].stop) begin
            check("vec_beats", beat_d.size(), 32'd1);
            if (beat_d.size() > 0) begin
               check("vec_data", {24'd0, beat_d[0]}, {24'd0, vecs[v].data});
               check("vec_time", beat_t[0], t0 + LAT);
            end
            check("vec_tv_cycles", tv_cycles, 32'd1);
            check("vec_fe", fe_t.size(), 32'd0);
            check("vec_busy_first", busy_first, t0 + 1);
            check("vec_busy_last", busy_last, t0 + LAT - 1);
         end else begin
            check("vec_bad_beats", beat_d.size(), 32'd0);
            check("vec_bad_fe", fe_t.size(), 32'd1);
            if (fe_t.size() > 0) check("vec_bad_fe_time", fe_t[0], t0 + LAT);
         end
         idle(CPB);
      end

      // back-to-back frames with no idle gap
      clear_mon();
      send_frame(8'hA5, 1'b1, t0);
      send_frame(8'h3C, 1'b1, t1);
      idle(20);
      check("b2b_beats", beat_d.size(), 32'd2);
      if (beat_d.size() == 2) begin
         check("b2b_d0", {24'd0, beat_d[0]}, 32'hA5);
         check("b2b_d1", {24'd0, beat_d[1]}, 32'h3C);
         check("b2b_gap", beat_t[1] - beat_t[0], 32'd2500);
      end
      check("b2b_errs", fe_t.size() + oe_t.size(), 32'd0);

      // false start: 50-cycle glitch
      clear_mon();
      uart_rxd = 1'b0; t0 = cyc;
      repeat (50) @(posedge clk);
      #1;
      idle(400);
      check("fs_beats", tv_cycles, 32'd0);
      check("fs_errs", fe_t.size() + oe_t.size(), 32'd0);
      check("fs_busy_last", busy_last, t0 + H);

      // break: line low for 3000 cycles, then a normal frame
      clear_mon();
      uart_rxd = 1'b0; t0 = cyc;
      repeat (3000) @(posedge clk);
      #1;
      idle(100);
      check("brk_fe_count", fe_t.size(), 32'd1);
      if (fe_t.size() > 0) check("brk_fe_time", fe_t[0], t0 + LAT);
      check("brk_tvalid", tv_cycles, 32'd0);
      check("brk_busy_last", busy_last, t0 + 3000);
      clear_mon();
      send_frame(8'h12, 1'b1, t0);
      idle(10);
      check("brk_after_beats", beat_d.size(), 32'd1);
      if (beat_d.size() > 0) check("brk_after_data", {24'd0, beat_d[0]}, 32'h12);

      // overrun with tready low
      clear_mon();
      tready = 1'b0;
      send_frame(8'hA5, 1'b1, t0);
      send_frame(8'h3C, 1'b1, t1);
      idle(50);
      check("ovr_oe_count", oe_t.size(), 32'd1);
      if (oe_t.size() > 0) check("ovr_oe_time", oe_t[0], t1 + LAT);
      check("ovr_tdata", {24'd0, tdata}, 32'h3C);
      check("ovr_tvalid", {31'd0, tvalid}, 32'd1);
      tready = 1'b1;
      idle(10);
      check("ovr_beats", beat_d.size(), 32'd1);
      if (beat_d.size() > 0) check("ovr_beat_data", {24'd0, beat_d[0]}, 32'h3C);
      check("ovr_tvalid_after", {31'd0, tvalid}, 32'd0);

      // handshake coinciding with completion of the next byte
      clear_mon();
      tready = 1'b0;
      send_frame(8'h5A, 1'b1, t0);
      fork
         send_frame(8'hC3, 1'b1, t1);
         begin
            repeat (LAT - 1) @(posedge clk);
            #1;
            tready = 1'b1;
            @(posedge clk);
            #1;
            tready = 1'b0;
         end
      join
      idle(10);
      check("coin_oe", oe_t.size(), 32'd0);
      check("coin_beats", beat_d.size(), 32'd1);
      if (beat_d.size() > 0) begin
         check("coin_beat_data", {24'd0, beat_d[0]}, 32'h5A);
         check("coin_beat_time", beat_t[0], t1 + LAT - 1);
      end
      check("coin_tvalid", {31'd0, tvalid}, 32'd1);
      check("coin_tdata", {24'd0, tdata}, 32'hC3);
      tready = 1'b1;
      idle(5);
      check("coin_beats2", beat_d.size(), 32'd2);

      // reset during bit 4 of 0xFF
      clear_mon();
      fork
         send_frame(8'hFF, 1'b1, t0);
         begin
            repeat (1300) @(posedge clk);
            #1;
            reset_n = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            reset_n = 1'b1;
         end
      join
      idle(20);
      check("rmf_tvalid", tv_cycles, 32'd0);
      check("rmf_errs", fe_t.size() + oe_t.size(), 32'd0);
      clear_mon();
      send_frame(8'h81, 1'b1, t0);
      idle(10);
      check("rmf_after_beats", beat_d.size(), 32'd1);
      if (beat_d.size() > 0) check("rmf_after_data", {24'd0, beat_d[0]}, 32'h81);

      // random bytes and gaps against the timing model
      clear_mon();
      exp_d.delete(); exp_t.delete();
      for (int k = 0; k < 6; k++) begin
         idle($urandom_range(0, 30));
         rd = 8'($urandom);
         send_frame(rd, 1'b1, t0);
         exp_d.push_back(rd);
         exp_t.push_back(t0 + LAT);
      end
      idle(20);
      check("rnd_count", beat_d.size(), exp_d.size());
      for (int k = 0; k < 6; k++) begin
         if (k < beat_d.size()) begin
            check("rnd_data", {24'd0, beat_d[k]}, {24'd0, exp_d[k]});
            check("rnd_time", beat_t[k], exp_t[k]);
         end
      end
      check("rnd_errs", fe_t.size() + oe_t.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
